ray_scene_intersection: RTL and testbench

Scene-level ray intersector that tests one ray against a table of up to `NUM_SPHERES` spheres, each with its own centre and radius. It streams one request per sphere into an external pipelined ray/sphere core over AXI-Stream, collects the in-order `t` results, and emits the nearest valid hit and its sphere index. It sits between the ray generator and the shading stage, replacing the single-sphere, unit-radius path.

---
 rtl/ray_scene_intersection_pkg.sv | 45 ++++
 rtl/ray_scene_intersection_nearest_hit_tracker.sv | 61 ++++++
 rtl/ray_scene_intersection.sv | 165 ++++++++++++++++
 tb/tb_ray_scene_intersection.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_scene_intersection_pkg.sv
// Shared types, constants and helpers for the scene-level ray intersector.
// Struct typedefs describe the double-precision field layout of the ray,
// sphere and vector words carried on the AXI-Stream buses.
package ray_pkg;

   localparam int FP_W = 64;

   typedef logic [FP_W-1:0] fp_t;

   typedef struct packed {
      fp_t z;
      fp_t y;
      fp_t x;
   } vec3_t;

   typedef struct packed {
      vec3_t dir;
      vec3_t origin;
   } ray_t;

   typedef struct packed {
      fp_t   r2;
      vec3_t centre;
   } sphere_t;

   localparam logic [63:0] FP_POS_INF_64 = 64'h7FF0_0000_0000_0000;
   localparam logic [31:0] FP_POS_INF_32 = 32'h7F80_0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_OUTPUT = 2'd3
   } state_e;

   // True for a non-negative, finite float (rejects negatives, NaN and inf).
   // The value is right-aligned in v; is_single selects the single layout.
   function automatic logic fp_valid_nonneg(input logic [63:0] v, input logic is_single);
      if (is_single) begin
         return !v[31] && (v[30:23] != 8'hFF);
      end
      return !v[63] && (v[62:52] != 11'h7FF);
   endfunction

endpackage

// File: rtl/ray_scene_intersection_nearest_hit_tracker.sv
// Nearest-hit register: keeps the smallest accepted t, its sphere index and
// a hit flag. clr restarts at +inf; upd offers a pre-validated candidate.
// Replacement is strict less-than, so ties keep the earlier (lower) index.
module nearest_hit_tracker
   import ray_pkg::*;
#(
   parameter int SIZE  = 64,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             upd,
   input  logic [SIZE-1:0]  upd_t,
   input  logic [IDX_W-1:0] upd_idx,
   output logic [SIZE-1:0]  best_t,
   output logic [IDX_W-1:0] best_idx,
   output logic             best_hit
);

   localparam logic [SIZE-1:0] POS_INF =
      (SIZE == 32) ? SIZE'(FP_POS_INF_32) : SIZE'(FP_POS_INF_64);

   logic [SIZE-1:0]  best_t_q,   best_t_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             best_hit_q, best_hit_d;

   // Non-negative floats order like unsigned integers once the sign is dropped.
   always_comb begin
      best_t_d   = best_t_q;
      best_idx_d = best_idx_q;
      best_hit_d = best_hit_q;
      if (clr) begin
         best_t_d   = POS_INF;
         best_idx_d = '0;
         best_hit_d = 1'b0;
      end else if (upd && (upd_t[SIZE-2:0] < best_t_q[SIZE-2:0])) begin
         best_t_d   = upd_t;
         best_idx_d = upd_idx;
         best_hit_d = 1'b1;
      end
   end

   // Tracker state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_t_q   <= POS_INF;
         best_idx_q <= '0;
         best_hit_q <= 1'b0;
      end else begin
         best_t_q   <= best_t_d;
         best_idx_q <= best_idx_d;
         best_hit_q <= best_hit_d;
      end
   end

   assign best_t   = best_t_q;
   assign best_idx = best_idx_q;
   assign best_hit = best_hit_q;

endmodule

// File: rtl/ray_scene_intersection.sv
// Scene-level intersector: streams one request per table sphere to an
// external pipelined ray/sphere core, collects in-order t results and
// reports the nearest valid hit with its sphere index.
// Optional macro RAY_SCENE_TMIN_EN: only t strictly above T_MIN counts as a
// hit, suppressing self-intersections of secondary rays.
module ray_scene_intersection
   import ray_pkg::*;
#(
   parameter int              SIZE        = 64,
   parameter int              NUM_SPHERES = 16,
   parameter int              IDX_W       = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1,
   parameter logic [SIZE-1:0] T_MIN       =
      (SIZE == 32) ? SIZE'(32'h3586_37BD) : SIZE'(64'h3EB0_C6F7_A0B5_ED8D)
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               sphere_wr_en,
   input  logic [IDX_W-1:0]   sphere_wr_addr,
   input  logic [3*SIZE-1:0]  sphere_wr_center,
   input  logic [SIZE-1:0]    sphere_wr_r2,
   input  logic [IDX_W:0]     num_spheres,
   input  logic [6*SIZE-1:0]  ray_axis_tdata,
   input  logic               ray_axis_tvalid,
   output logic               ray_axis_tready,
   output logic [10*SIZE-1:0] m_core_tdata,
   output logic               m_core_tvalid,
   input  logic               m_core_tready,
   input  logic [SIZE-1:0]    s_core_tdata,
   input  logic               s_core_tvalid,
   output logic               s_core_tready,
   output logic [SIZE-1:0]    t_axis_tdata,
   output logic [IDX_W-1:0]   t_axis_tuser,
   output logic               t_axis_thit,
   output logic               t_axis_tvalid,
   input  logic               t_axis_tready,
   output logic               busy
);

`ifdef RAY_SCENE_TMIN_EN
   localparam bit TMIN_EN = 1'b1;
`else
   localparam bit TMIN_EN = 1'b0;
`endif

   localparam logic [IDX_W:0] NS_MAX = (IDX_W+1)'(NUM_SPHERES);

   state_e              state_q, state_d;
   logic [6*SIZE-1:0]   ray_q, ray_d;
   logic [IDX_W:0]      n_q, n_d;
   logic [IDX_W:0]      issue_idx_q, issue_idx_d;
   logic [IDX_W:0]      rsp_idx_q, rsp_idx_d;

   logic [SIZE-1:0]     tbl_r2_q [NUM_SPHERES];
   logic [3*SIZE-1:0]   tbl_c_q  [NUM_SPHERES];

   logic                ray_hs, core_hs, rsp_hs, wr_ok, rsp_ok, rsp_done;
   logic [IDX_W:0]      n_sel, rsp_cnt_next;
   logic [IDX_W-1:0]    issue_sel;

   assign ray_axis_tready = (state_q == ST_IDLE);
   assign m_core_tvalid   = (state_q == ST_ISSUE);
   assign s_core_tready   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign t_axis_tvalid   = (state_q == ST_OUTPUT);
   assign busy            = (state_q != ST_IDLE);

   assign ray_hs  = ray_axis_tvalid && ray_axis_tready;
   assign core_hs = m_core_tvalid && m_core_tready;
   assign rsp_hs  = s_core_tvalid && s_core_tready;
   assign wr_ok   = sphere_wr_en && (state_q == ST_IDLE)
                    && (32'(sphere_wr_addr) < NUM_SPHERES);

   assign n_sel        = (num_spheres > NS_MAX) ? NS_MAX : num_spheres;
   assign rsp_cnt_next = rsp_idx_q + (IDX_W+1)'(rsp_hs);
   assign rsp_done     = (rsp_cnt_next == n_q);

   // Response validity: non-negative finite, optionally above the floor.
   assign rsp_ok = fp_valid_nonneg(64'(s_core_tdata), SIZE == 32)
                   && (!TMIN_EN || (s_core_tdata[SIZE-2:0] > T_MIN[SIZE-2:0]));

   // Out-of-range counters (between rays) read entry 0 harmlessly.
   assign issue_sel    = (issue_idx_q < NS_MAX) ? issue_idx_q[IDX_W-1:0] : '0;
   assign m_core_tdata = {tbl_r2_q[issue_sel], tbl_c_q[issue_sel], ray_q};

   // Next-state and counter logic for the IDLE/ISSUE/DRAIN/OUTPUT sequence.
   always_comb begin
      state_d     = state_q;
      ray_d       = ray_q;
      n_d         = n_q;
      issue_idx_d = issue_idx_q;
      rsp_idx_d   = rsp_idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ray_hs) begin
               ray_d       = ray_axis_tdata;
               n_d         = n_sel;
               issue_idx_d = '0;
               rsp_idx_d   = '0;
               state_d     = (n_sel == '0) ? ST_OUTPUT : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (rsp_hs) rsp_idx_d = rsp_cnt_next;
            if (core_hs) begin
               issue_idx_d = issue_idx_q + 1'b1;
               // A zero-latency core can return the last result alongside its request.
               if (issue_idx_q + 1'b1 == n_q) state_d = rsp_done ? ST_OUTPUT : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (rsp_hs) rsp_idx_d = rsp_cnt_next;
            if (rsp_done) state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (t_axis_tready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state, latched ray and counters.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         ray_q       <= '0;
         n_q         <= '0;
         issue_idx_q <= '0;
         rsp_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         ray_q       <= ray_d;
         n_q         <= n_d;
         issue_idx_q <= issue_idx_d;
         rsp_idx_q   <= rsp_idx_d;
      end
   end

   // Sphere table; writes land only while idle so an in-flight ray sees a stable scene.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < NUM_SPHERES; i++) begin
            tbl_r2_q[i] <= '0;
            tbl_c_q[i]  <= '0;
         end
      end else if (wr_ok) begin
         tbl_r2_q[sphere_wr_addr] <= sphere_wr_r2;
         tbl_c_q[sphere_wr_addr]  <= sphere_wr_center;
      end
   end

   nearest_hit_tracker #(
      .SIZE  (SIZE),
      .IDX_W (IDX_W)
   ) u_tracker (
      .clk      (aclk),
      .rst      (areset),
      .clr      (ray_hs),
      .upd      (rsp_hs && rsp_ok),
      .upd_t    (s_core_tdata),
      .upd_idx  (rsp_idx_q[IDX_W-1:0]),
      .best_t   (t_axis_tdata),
      .best_idx (t_axis_tuser),
      .best_hit (t_axis_thit)
   );

endmodule

// File: tb/tb_ray_scene_intersection.sv
// Directed bench for ray_scene_intersection with a latency-3 core model.
// The core model either intersects the requested sphere geometrically or
// replays a per-ray table of t values in request order.
module tb_ray_scene_intersection;

   localparam int SIZE = 64;
   localparam int NS   = 8;
   localparam int IW   = 3;
   localparam int L    = 3;

   localparam logic [63:0] F_0   = 64'h0000_0000_0000_0000;
   localparam logic [63:0] F_1   = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] F_1P5 = 64'h3FF8_0000_0000_0000;
   localparam logic [63:0] F_2   = 64'h4000_0000_0000_0000;
   localparam logic [63:0] F_3   = 64'h4008_0000_0000_0000;
   localparam logic [63:0] F_3P5 = 64'h400C_0000_0000_0000;
   localparam logic [63:0] F_4   = 64'h4010_0000_0000_0000;
   localparam logic [63:0] F_5   = 64'h4014_0000_0000_0000;
   localparam logic [63:0] F_6   = 64'h4018_0000_0000_0000;
   localparam logic [63:0] F_7   = 64'h401C_0000_0000_0000;
   localparam logic [63:0] F_8   = 64'h4020_0000_0000_0000;
   localparam logic [63:0] F_9   = 64'h4022_0000_0000_0000;
   localparam logic [63:0] F_10  = 64'h4024_0000_0000_0000;
   localparam logic [63:0] F_N2  = 64'hC000_0000_0000_0000;
   localparam logic [63:0] F_NAN = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] F_INF = 64'h7FF0_0000_0000_0000;

   logic               aclk = 1'b0;
   logic               areset = 1'b1;
   logic               sphere_wr_en = 1'b0;
   logic [IW-1:0]      sphere_wr_addr = '0;
   logic [3*SIZE-1:0]  sphere_wr_center = '0;
   logic [SIZE-1:0]    sphere_wr_r2 = '0;
   logic [IW:0]        num_spheres = '0;
   logic [6*SIZE-1:0]  ray_axis_tdata = '0;
   logic               ray_axis_tvalid = 1'b0;
   logic               ray_axis_tready;
   logic [10*SIZE-1:0] m_core_tdata;
   logic               m_core_tvalid;
   logic               m_core_tready = 1'b1;
   logic [SIZE-1:0]    s_core_tdata;
   logic               s_core_tvalid;
   logic               s_core_tready;
   logic [SIZE-1:0]    t_axis_tdata;
   logic [IW-1:0]      t_axis_tuser;
   logic               t_axis_thit;
   logic               t_axis_tvalid;
   logic               t_axis_tready = 1'b0;
   logic               busy;

   int tests = 0;
   int fails = 0;

   ray_scene_intersection #(
      .SIZE        (SIZE),
      .NUM_SPHERES (NS),
      .IDX_W       (IW)
   ) dut (
      .aclk             (aclk),
      .areset           (areset),
      .sphere_wr_en     (sphere_wr_en),
      .sphere_wr_addr   (sphere_wr_addr),
      .sphere_wr_center (sphere_wr_center),
      .sphere_wr_r2     (sphere_wr_r2),
      .num_spheres      (num_spheres),
      .ray_axis_tdata   (ray_axis_tdata),
      .ray_axis_tvalid  (ray_axis_tvalid),
      .ray_axis_tready  (ray_axis_tready),
      .m_core_tdata     (m_core_tdata),
      .m_core_tvalid    (m_core_tvalid),
      .m_core_tready    (m_core_tready),
      .s_core_tdata     (s_core_tdata),
      .s_core_tvalid    (s_core_tvalid),
      .s_core_tready    (s_core_tready),
      .t_axis_tdata     (t_axis_tdata),
      .t_axis_tuser     (t_axis_tuser),
      .t_axis_thit      (t_axis_thit),
      .t_axis_tvalid    (t_axis_tvalid),
      .t_axis_tready    (t_axis_tready),
      .busy             (busy)
   );

   always #5 aclk = ~aclk;

   // ---------------- core model ----------------
   bit          geo_mode = 1'b1;
   bit          bp_en = 1'b0;
   int          req_cnt = 0;
   int          base = 0;
   logic [63:0] rsp_tab [16];
   logic [63:0] pipe_d [L];
   logic        pipe_v [L];

   // Nearest intersection of a unit-direction ray with a sphere, or -1.0 on a miss.
   function automatic logic [63:0] geo_t(input logic [639:0] req);
      real ox, oy, oz, dx, dy, dz, cx, cy, cz, r2, lx, ly, lz, tc, d2, disc;
      ox = $bitstoreal(req[63:0]);    oy = $bitstoreal(req[127:64]);  oz = $bitstoreal(req[191:128]);
      dx = $bitstoreal(req[255:192]); dy = $bitstoreal(req[319:256]); dz = $bitstoreal(req[383:320]);
      cx = $bitstoreal(req[447:384]); cy = $bitstoreal(req[511:448]); cz = $bitstoreal(req[575:512]);
      r2 = $bitstoreal(req[639:576]);
      lx = cx - ox; ly = cy - oy; lz = cz - oz;
      tc = lx*dx + ly*dy + lz*dz;
      d2 = lx*lx + ly*ly + lz*lz - tc*tc;
      disc = r2 - d2;
      if (disc < 0.0) return $realtobits(-1.0);
      return $realtobits(tc - $sqrt(disc));
   endfunction

   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < L; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_d[i] <= '0;
         end
      end else begin
         pipe_v[0] <= m_core_tvalid && m_core_tready;
         pipe_d[0] <= geo_mode ? geo_t(m_core_tdata) : rsp_tab[(req_cnt - base) & 15];
         for (int i = 1; i < L; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
         if (m_core_tvalid && m_core_tready) req_cnt <= req_cnt + 1;
      end
   end

   assign s_core_tvalid = pipe_v[L-1];
   assign s_core_tdata  = pipe_d[L-1];

   always @(negedge aclk) m_core_tready <= bp_en ? ~m_core_tready : 1'b1;

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr_sphere(input int addr, input logic [63:0] cz, input logic [63:0] r2);
      @(negedge aclk);
      sphere_wr_en     = 1'b1;
      sphere_wr_addr   = IW'(addr);
      sphere_wr_center = {cz, F_0, F_0};
      sphere_wr_r2     = r2;
      @(negedge aclk);
      sphere_wr_en     = 1'b0;
   endtask

   // Handshake a ray at the next edge (cycle 0); returns at the cycle-1 sample point.
   task automatic start_ray(input string tag, input logic [IW:0] num);
      @(negedge aclk);
      chk({tag, "_ready"}, 64'(ray_axis_tready), 64'd1);
      num_spheres     = num;
      ray_axis_tvalid = 1'b1;
      @(negedge aclk);
      ray_axis_tvalid = 1'b0;
      sphere_wr_en    = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
   endtask

   task automatic wait_check(input string tag, input int start, input int exp_cyc,
                             input logic [63:0] exp_t, input logic [IW-1:0] exp_idx,
                             input logic exp_hit, input int hold);
      int cyc;
      cyc = start;
      while (!t_axis_tvalid && cyc < 400) begin
         @(negedge aclk);
         cyc++;
      end
      chk({tag, "_tvalid"}, 64'(t_axis_tvalid), 64'd1);
      if (exp_cyc >= 0) chk({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_t"}, t_axis_tdata, exp_t);
      chk({tag, "_tuser"}, 64'(t_axis_tuser), 64'(exp_idx));
      chk({tag, "_thit"}, 64'(t_axis_thit), 64'(exp_hit));
      for (int i = 0; i < hold; i++) begin
         @(negedge aclk);
         chk({tag, "_hold_v"}, 64'(t_axis_tvalid), 64'd1);
         chk({tag, "_hold_t"}, t_axis_tdata, exp_t);
         chk({tag, "_hold_u"}, 64'(t_axis_tuser), 64'(exp_idx));
      end
      t_axis_tready = 1'b1;
      @(negedge aclk);
      t_axis_tready = 1'b0;
      chk({tag, "_done_v"}, 64'(t_axis_tvalid), 64'd0);
      chk({tag, "_done_busy"}, 64'(busy), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   int req0;

   initial begin
      ray_axis_tdata = {F_1, F_0, F_0, F_0, F_0, F_0};   // dir +z, origin 0
      repeat (3) @(negedge aclk);
      chk("rst_tvalid", 64'(t_axis_tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ray_ready", 64'(ray_axis_tready), 64'd1);
      chk("rst_tdata", t_axis_tdata, F_INF);
      chk("rst_core_valid", 64'(m_core_tvalid), 64'd0);
      chk("rst_core_ready", 64'(s_core_tready), 64'd0);
      areset = 1'b0;

      // Two spheres on +z: z=5 r=1 (t=4), z=10 r=2 (t=8).
      wr_sphere(0, F_5, F_1);
      wr_sphere(1, F_10, F_4);
      geo_mode = 1'b1;
      start_ray("geo", 4'd2);
      wait_check("geo", 1, 2 + L + 1, F_4, 3'd0, 1'b1, 0);

      // Write at accept is seen (sphere1 z=3 -> t=2); write while busy is dropped.
      @(negedge aclk);
      sphere_wr_en     = 1'b1;
      sphere_wr_addr   = 3'd1;
      sphere_wr_center = {F_3, F_0, F_0};
      sphere_wr_r2     = F_1;
      start_ray("wr_accept", 4'd2);
      sphere_wr_en     = 1'b1;
      sphere_wr_addr   = 3'd0;
      sphere_wr_center = {F_2, F_0, F_0};
      sphere_wr_r2     = F_1;
      @(negedge aclk);
      sphere_wr_en     = 1'b0;
      wait_check("wr_accept", 2, 2 + L + 1, F_2, 3'd1, 1'b1, 0);
      start_ray("wr_busy", 4'd2);
      wait_check("wr_busy", 1, 2 + L + 1, F_2, 3'd1, 1'b1, 0);

      // Empty scene: immediate miss, no core traffic.
      req0 = req_cnt;
      start_ray("empty", 4'd0);
      wait_check("empty", 1, 1, F_INF, 3'd0, 1'b0, 0);
      chk("empty_reqs", 64'(req_cnt - req0), 64'd0);

      // Negative, NaN and inf responses are all misses.
      geo_mode = 1'b0;
      rsp_tab[0] = F_N2; rsp_tab[1] = F_NAN; rsp_tab[2] = F_INF;
      base = req_cnt;
      start_ray("reject", 4'd3);
      wait_check("reject", 1, 3 + L + 1, F_INF, 3'd0, 1'b0, 0);
      chk("reject_reqs", 64'(req_cnt - base), 64'd3);

      // Tie at indices 3 and 7 keeps 3; num_spheres=12 clamps to 8.
      for (int i = 0; i < 16; i++) rsp_tab[i] = F_5;
      rsp_tab[3] = F_2; rsp_tab[7] = F_2;
      base = req_cnt;
      start_ray("tie", 4'd12);
      wait_check("tie", 1, 8 + L + 1, F_2, 3'd3, 1'b1, 0);
      chk("tie_reqs", 64'(req_cnt - base), 64'd8);

      // Core back-pressure toggling and output held off for 10 cycles.
      rsp_tab[0] = F_9; rsp_tab[1] = F_7; rsp_tab[2] = F_3P5;
      rsp_tab[3] = F_8; rsp_tab[4] = F_1P5; rsp_tab[5] = F_6;
      base = req_cnt;
      bp_en = 1'b1;
      start_ray("bp", 4'd6);
      wait_check("bp", 1, -1, F_1P5, 3'd4, 1'b1, 10);
      bp_en = 1'b0;
      chk("bp_reqs", 64'(req_cnt - base), 64'd6);

      // t=+0.0 at index 0 and 3.0 at index 1.
      rsp_tab[0] = F_0; rsp_tab[1] = F_3;
      base = req_cnt;
      start_ray("tmin", 4'd2);
`ifdef RAY_SCENE_TMIN_EN
      wait_check("tmin", 1, 2 + L + 1, F_3, 3'd1, 1'b1, 0);
`else
      wait_check("tmin", 1, 2 + L + 1, F_0, 3'd0, 1'b1, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
